// File: rtl/mvau_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mvau_weight_streamer
// Brief    : Weight-memory read sequencer feeding an AXI-Stream master through
//            a 2-entry skid buffer that absorbs the 1-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module mvau_weight_streamer #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_out,
  output logic [SIMD*TW-1:0]      m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int c_DW     = SIMD * TW;
  localparam int c_REP_BW = $clog2(NUM_REPS + 1);
  localparam logic [WMEM_ADDR_BW-1:0] c_ADDR_MAX = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [c_REP_BW-1:0]     c_REP_MAX  = c_REP_BW'(NUM_REPS - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [WMEM_ADDR_BW-1:0] r_addr;
  logic [c_REP_BW-1:0]     r_rep;
  logic                    r_rd_vld;
  logic                    r_rd_last;
  logic [c_DW-1:0]         r_d0;
  logic [c_DW-1:0]         r_d1;
  logic                    r_l0;
  logic                    r_l1;
  logic [1:0]              r_cnt;

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_room;
  logic       w_empty;
  logic       w_last_issue;
  logic [1:0] w_occ_nxt;

  assign w_push    = r_rd_vld;
  assign w_pop     = m_axis_tvalid && m_axis_tready;
  // Occupancy the buffer will have next cycle; one more read fits only if it stays <= 1.
  assign w_occ_nxt = r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
  assign w_room    = (w_occ_nxt <= 2'd1);
  assign w_empty   = (r_cnt == 2'd0) && !r_rd_vld;
  assign w_last_issue = w_issue && (r_addr == c_ADDR_MAX) && (r_rep == c_REP_MAX);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start)        w_state_nxt = c_ST_RUN;
      c_ST_RUN:   if (w_last_issue) w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: if (w_empty)      w_state_nxt = c_ST_IDLE;
      default:                      w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        busy    = 1'b1;
        w_issue = w_room;
      end
      c_ST_DRAIN: begin
        busy = 1'b1;
        done = w_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr    <= '0;
      r_rep     <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_last <= (r_addr == c_ADDR_MAX);
        if (r_addr == c_ADDR_MAX) begin
          r_addr <= '0;
          r_rep  <= (r_rep == c_REP_MAX) ? '0 : r_rep + 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  // Entry 0 is always the head; entry 1 only holds data while entry 0 is full.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_pop) begin
        if (r_cnt == 2'd2) begin
          r_d0 <= r_d1;
          r_l0 <= r_l1;
          if (w_push) begin
            r_d1 <= wmem_out;
            r_l1 <= r_rd_last;
          end
        end else if (w_push) begin
          r_d0 <= wmem_out;
          r_l0 <= r_rd_last;
        end
      end else if (w_push) begin
        if (r_cnt == 2'd0) begin
          r_d0 <= wmem_out;
          r_l0 <= r_rd_last;
        end else begin
          r_d1 <= wmem_out;
          r_l1 <= r_rd_last;
        end
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign wmem_addr     = r_addr;
  assign m_axis_tvalid = (r_cnt != 2'd0);
  assign m_axis_tdata  = r_d0;
  assign m_axis_tlast  = r_l0 && m_axis_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_mvau_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvau_weight_streamer
// Brief    : Self-checking bench: three streamer configurations against a
//            word-sequence reference model with random memory and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvau_weight_streamer;

  localparam int N = 3;

  logic aclk = 1'b0;
  logic aresetn;
  logic [N-1:0] start, tready, busy, done, tvalid, tlast;
  logic [N-1:0][3:0] addr;
  logic [N-1:0][1:0] wout, tdata;
  logic [1:0] mem [N][4];
  logic [N-1:0] p_valid, p_ready, p_last;
  logic [N-1:0][1:0] p_data;
  int total = 0;
  int bad = 0;
  int hs [N];
  int done_cnt [N];

  always #5 aclk = ~aclk;

  mvau_weight_streamer #(.SIMD(2), .TW(1), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4), .NUM_REPS(1)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .wmem_addr(addr[0]), .wmem_out(wout[0]), .m_axis_tdata(tdata[0]),
    .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]), .m_axis_tlast(tlast[0]));

  mvau_weight_streamer #(.SIMD(2), .TW(1), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4), .NUM_REPS(3)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .wmem_addr(addr[1]), .wmem_out(wout[1]), .m_axis_tdata(tdata[1]),
    .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]), .m_axis_tlast(tlast[1]));

  mvau_weight_streamer #(.SIMD(2), .TW(1), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4), .NUM_REPS(2)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .wmem_addr(addr[2]), .wmem_out(wout[2]), .m_axis_tdata(tdata[2]),
    .m_axis_tvalid(tvalid[2]), .m_axis_tready(tready[2]), .m_axis_tlast(tlast[2]));

  function automatic int depth_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int reps_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Weight memory with a registered read port.
  always @(posedge aclk) begin
    for (int i = 0; i < N; i++) wout[i] <= mem[i][addr[i][1:0]];
  end

  // Reference model: handshake k must carry mem[k mod depth], tlast on pass end.
  always @(negedge aclk) begin
    for (int i = 0; i < N; i++) begin
      if (!aresetn) begin
        hs[i] = 0;
        p_valid[i] = 1'b0;
      end else begin
        check("addr_range", 32'(addr[i] < 4'(depth_of(i))), 32'd1);
        if (p_valid[i] && !p_ready[i]) begin
          check("valid_hold", 32'(tvalid[i]), 32'd1);
          check("data_hold", 32'(tdata[i]), 32'(p_data[i]));
          check("last_hold", 32'(tlast[i]), 32'(p_last[i]));
        end
        if (tvalid[i] && tready[i]) begin
          check("hs_data", 32'(tdata[i]), 32'(mem[i][2'(hs[i] % depth_of(i))]));
          check("hs_last", 32'(tlast[i]), 32'((hs[i] % depth_of(i)) == depth_of(i) - 1));
          hs[i]++;
        end
        if (done[i]) begin
          check("done_words", 32'(hs[i]), 32'(depth_of(i) * reps_of(i)));
          check("done_busy", 32'(busy[i]), 32'd1);
          done_cnt[i]++;
          hs[i] = 0;
        end
        p_valid[i] = tvalid[i];
        p_ready[i] = tready[i];
        p_data[i]  = tdata[i];
        p_last[i]  = tlast[i];
      end
    end
  end

  task automatic start_pulse(input int i);
    @(posedge aclk); #1;
    start[i] = 1'b1;
    @(posedge aclk); #1;
    start[i] = 1'b0;
  endtask

  task automatic run_check(input int i);
    int dr;
    int c;
    int d0;
    dr = depth_of(i) * reps_of(i);
    c  = 0;
    d0 = done_cnt[i];
    start_pulse(i);
    do begin
      @(posedge aclk); #1;
      c++;
      if (c == 1) check("lat_c1_valid", 32'(tvalid[i]), 32'd0);
      if (c == 2) begin
        check("lat_c2_valid", 32'(tvalid[i]), 32'd1);
        check("lat_c2_data", 32'(tdata[i]), 32'(mem[i][0]));
      end
    end while (!done[i] && c < dr + 20);
    check("done_cycle", 32'(c), 32'(dr + 2));
    @(posedge aclk); #1;
    check("idle_busy", 32'(busy[i]), 32'd0);
    check("idle_valid", 32'(tvalid[i]), 32'd0);
    check("done_once", 32'(done_cnt[i] - d0), 32'd1);
  endtask

  initial begin
    int c;
    int d0;
    aresetn = 1'b0;
    start   = '0;
    tready  = '1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++)
        mem[i][j] = (i == 0) ? 2'(j) : 2'($urandom_range(0, 3));

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    run_check(0);
    run_check(1);
    run_check(2);

    // Backpressure: stall after the first word, then random ready.
    tready[0] = 1'b0;
    d0 = done_cnt[0];
    start_pulse(0);
    c = 0;
    while (!tvalid[0] && c < 10) begin
      @(posedge aclk); #1;
      c++;
    end
    check("bp_first_valid", 32'(tvalid[0]), 32'd1);
    repeat (5) begin
      @(posedge aclk); #1;
      check("bp_valid", 32'(tvalid[0]), 32'd1);
      check("bp_data", 32'(tdata[0]), 32'(mem[0][0]));
    end
    check("bp_addr_credit", 32'(addr[0]), 32'd2);
    c = 0;
    while (!done[0] && c < 200) begin
      tready[0] = 1'($urandom_range(0, 1));
      @(posedge aclk); #1;
      c++;
    end
    check("bp_done_seen", 32'(done[0]), 32'd1);
    tready[0] = 1'b1;
    @(posedge aclk); #1;
    check("bp_done_once", 32'(done_cnt[0] - d0), 32'd1);

    // start while busy and in the done cycle is ignored.
    d0 = done_cnt[1];
    start_pulse(1);
    repeat (3) @(posedge aclk);
    start_pulse(1);
    c = 0;
    while (!done[1] && c < 100) begin
      @(posedge aclk); #1;
      c++;
    end
    check("ign_done_seen", 32'(done[1]), 32'd1);
    start[1] = 1'b1;
    @(posedge aclk); #1;
    start[1] = 1'b0;
    repeat (25) @(posedge aclk);
    #1;
    check("ign_done_once", 32'(done_cnt[1] - d0), 32'd1);
    check("ign_busy", 32'(busy[1]), 32'd0);
    check("ign_valid", 32'(tvalid[1]), 32'd0);

    // Asynchronous reset after two handshakes.
    d0 = done_cnt[0];
    start_pulse(0);
    c = 0;
    while (hs[0] < 2 && c < 20) begin
      @(posedge aclk); #1;
      c++;
    end
    check("pre_rst_hs", 32'(hs[0]), 32'd2);
    check("pre_rst_valid", 32'(tvalid[0]), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", 32'(tvalid[0]), 32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_addr", 32'(addr[0]), 32'd0);
    check("arst_tdata", 32'(tdata[0]), 32'd0);
    check("arst_tlast", 32'(tlast[0]), 32'd0);
    check("arst_done", 32'(done[0]), 32'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) begin
      @(posedge aclk); #1;
      check("post_rst_valid", 32'(tvalid[0]), 32'd0);
      check("post_rst_busy", 32'(busy[0]), 32'd0);
    end
    check("post_rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
    run_check(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
